// File: rtl/prog_load_ctrl_pkg.sv
// Shared definitions for the program loader: state encodings, memory-select bit,
// and the per-state reset/ownership levels driven to the rest of the system.
package prog_load_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  localparam int MEM_SEL_BIT = 14;

  typedef struct packed {
    logic upg_rst;
    logic cpu_rst_n;
    logic mem_owner;
  } lvl_t;

  function automatic lvl_t state_levels(input state_t s);
    lvl_t l;
    case (s)
      ST_RUN:  l = '{upg_rst: 1'b1, cpu_rst_n: 1'b1, mem_owner: 1'b0};
      ST_LOAD: l = '{upg_rst: 1'b0, cpu_rst_n: 1'b0, mem_owner: 1'b1};
      ST_HOLD: l = '{upg_rst: 1'b1, cpu_rst_n: 1'b0, mem_owner: 1'b1};
      default: l = '{upg_rst: 1'b1, cpu_rst_n: 1'b0, mem_owner: 1'b0};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/prog_load_ctrl_edge_rise.sv
// Rising-edge detector against a registered copy of the input; pulse is
// combinational in the cycle the input first reads high. No backpressure.
module edge_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= din;
  end

  assign rise = din & ~prev;

endmodule

// File: rtl/prog_load_ctrl.sv
// Owns the CPU/UART-programmer reset sequencing and forwards loader writes to memory.
// Writes and state levels appear one cycle after they are sampled; no backpressure.
module prog_load_ctrl
  import prog_load_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 23_000_000,
  parameter int RST_HOLD       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_pg,
  input  logic        upg_wen,
  input  logic [14:0] upg_adr,
  input  logic [31:0] upg_dat,
  input  logic        upg_done,
  output logic        upg_rst,
  output logic        cpu_rst_n,
  output logic        mem_owner,
  output logic        imem_we,
  output logic        dmem_we,
  output logic [13:0] mem_adr,
  output logic [31:0] mem_dat,
  output logic [15:0] word_count,
  output logic        load_err,
  output logic [1:0]  state_dbg
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  state_t        state, state_nxt;
  lvl_t          lvl_nxt;
  logic          start_rise, done_rise;
  logic [TW-1:0] to_cnt;
  logic          wr_seen;
  logic          timeout;
  logic [HW-1:0] hold_cnt;
  logic          load_wr;
  logic          start_ok;

  edge_rise u_start_edge (.clk(clk), .rst_n(rst_n), .din(start_pg), .rise(start_rise));
  edge_rise u_done_edge  (.clk(clk), .rst_n(rst_n), .din(upg_done), .rise(done_rise));

  assign timeout   = (to_cnt == TW'(TIMEOUT_CYCLES));
  assign load_wr   = (state == ST_LOAD) && upg_wen;
  assign start_ok  = start_rise && ((state == ST_RUN) || (state == ST_ERR));
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nxt;
  end

  // upg_done has priority over a coincident timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN, ST_ERR: if (start_rise) state_nxt = ST_LOAD;
      ST_LOAD: begin
        if (done_rise)    state_nxt = ST_HOLD;
        else if (timeout) state_nxt = ST_ERR;
      end
      ST_HOLD: if (hold_cnt == '0) state_nxt = ST_RUN;
      default: state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    lvl_nxt = state_levels(state);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upg_rst   <= 1'b1;
      cpu_rst_n <= 1'b0;
      mem_owner <= 1'b0;
    end else begin
      upg_rst   <= lvl_nxt.upg_rst;
      cpu_rst_n <= lvl_nxt.cpu_rst_n;
      mem_owner <= lvl_nxt.mem_owner;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_we    <= 1'b0;
      dmem_we    <= 1'b0;
      mem_adr    <= '0;
      mem_dat    <= '0;
      word_count <= '0;
      load_err   <= 1'b0;
    end else begin
      imem_we <= load_wr && !upg_adr[MEM_SEL_BIT];
      dmem_we <= load_wr &&  upg_adr[MEM_SEL_BIT];
      if (load_wr) begin
        mem_adr <= upg_adr[MEM_SEL_BIT-1:0];
        mem_dat <= upg_dat;
        if (word_count != 16'hFFFF) word_count <= word_count + 16'd1;
      end else if (start_ok) begin
        word_count <= '0;
      end
      if (start_ok)
        load_err <= 1'b0;
      else if ((state == ST_LOAD) && timeout && !done_rise)
        load_err <= 1'b1;
    end
  end

  // Idle timer only arms after the first write so the loader may wait forever to begin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt  <= '0;
      wr_seen <= 1'b0;
    end else if (state != ST_LOAD) begin
      to_cnt  <= '0;
      wr_seen <= 1'b0;
    end else if (upg_wen) begin
      to_cnt  <= '0;
      wr_seen <= 1'b1;
    end else if (wr_seen && !timeout) begin
      to_cnt  <= to_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      hold_cnt <= '0;
    else if ((state == ST_LOAD) && done_rise)
      hold_cnt <= HW'(RST_HOLD - 1);
    else if ((state == ST_HOLD) && (hold_cnt != '0))
      hold_cnt <= hold_cnt - HW'(1);
  end

endmodule

// File: doc/prog_load_ctrl.md
PROG_LOAD_CTRL -- requirements
Module: prog_load_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 23_000_000: idle cycles tolerated between UART writes once loading has begun (1 s at 23 MHz).
REQ-002 Parameter RST_HOLD, default 16: cycles the CPU stays in reset after a successful load.
REQ-003 clk  input  1: single clock; all inputs are synchronous to it.
REQ-004 rst_n  input  1: reset, asynchronous and active-low.
REQ-005 start_pg  input  1: debounced program-load request, level.
REQ-006 upg_wen  input  1: UART programmer word-write strobe.
REQ-007 upg_adr  input  15: bit 14 selects memory (0 = instruction, 1 = data); bits 13:0 are the word address.
REQ-008 upg_dat  input  32: UART programmer write data.
REQ-009 upg_done  input  1: UART programmer load-complete flag, level.
REQ-010 upg_rst  output  1: active-high reset to the UART programmer.
REQ-011 cpu_rst_n  output  1: active-low reset to the datapath.
REQ-012 mem_owner  output  1: memory write-port owner (1 = loader, 0 = CPU).
REQ-013 imem_we, dmem_we  output  1 each: registered loader write enables.
REQ-014 mem_adr  output  14: registered loader word address.
REQ-015 mem_dat  output  32: registered loader write data.
REQ-016 word_count  output  16: words written in the current or last load; saturates at 0xFFFF.
REQ-017 load_err  output  1: last load timed out.
REQ-018 state_dbg  output  2: current state encoding, for LEDs.

Function
REQ-019 States and encodings: RUN=0, LOAD=1, HOLD=2, ERR=3.
REQ-020 Output levels per state:
- RUN: upg_rst=1, cpu_rst_n=1, mem_owner=0.
- LOAD: upg_rst=0, cpu_rst_n=0, mem_owner=1.
- HOLD: upg_rst=1, cpu_rst_n=0, mem_owner=1.
- ERR: upg_rst=1, cpu_rst_n=0, mem_owner=0.
REQ-021 Outputs are driven from registers, so each level takes effect in the cycle after the state changes.
REQ-022 A rising edge of start_pg (registered previous value) in RUN or ERR moves to LOAD; in the same cycle, word_count clears to 0, load_err clears, and the timeout counter clears.
REQ-023 start_pg high for one cycle or for many produces exactly one LOAD entry; start_pg is ignored in LOAD and HOLD.
REQ-024 In LOAD, upg_wen=1 produces, one cycle later:
- imem_we = ~upg_adr[14] and dmem_we = upg_adr[14];
- mem_adr = upg_adr[13:0] and mem_dat = upg_dat;
- word_count incremented by 1.
REQ-025 Outside LOAD, imem_we and dmem_we are 0 and upg_wen is ignored.
REQ-026 The timeout counter runs in LOAD only after the first write; it clears on every upg_wen and saturates at TIMEOUT_CYCLES.
REQ-027 LOAD moves to ERR with load_err=1 when the counter reaches TIMEOUT_CYCLES.
REQ-028 LOAD waits indefinitely until the first write.
REQ-029 A rising edge of upg_done in LOAD moves to HOLD and loads the hold counter with RST_HOLD-1.
REQ-030 If upg_wen and the upg_done edge occur in the same cycle, the write is still forwarded and counted.
REQ-031 If the upg_done edge and timeout occur in the same cycle, upg_done wins and the next state is HOLD.
REQ-032 HOLD decrements the hold counter each cycle and moves to RUN in the cycle after it reads 0; the CPU is held in reset for exactly RST_HOLD cycles of HOLD.
REQ-033 ERR holds until the next start_pg edge.
REQ-034 word_count and load_err hold their values in RUN and ERR.

Reset
REQ-035 rst_n low asynchronously forces: state=RUN, upg_rst=1, cpu_rst_n=0, mem_owner=0, imem_we=0, dmem_we=0, mem_adr=0, mem_dat=0, word_count=0, load_err=0, all counters=0, start_pg and upg_done edge registers=0.
REQ-036 On the first clk after rst_n rises, cpu_rst_n goes to 1.
REQ-037 Reset asserted during LOAD aborts the load; no write enable is asserted after assertion.

Structure
REQ-038 A shared package holds the state encodings and the memory-select bit index (14).
REQ-039 One sub-module, edge_rise (registered rising-edge detector), is instantiated for start_pg and for upg_done.
REQ-040 The timeout and hold counters remain in this module.

Verification
REQ-041 Idle after reset, then start_pg pulse of 3 cycles: exactly one LOAD entry; cpu_rst_n=0 and upg_rst=0 within 2 cycles.
REQ-042 In LOAD, writes to adr 0x0005 data 0xDEADBEEF and to adr 0x4003 data 0x12345678: imem_we with mem_adr=5, then dmem_we with mem_adr=3; word_count=2.
REQ-043 upg_done rises with RST_HOLD=16: HOLD lasts 16 cycles, then RUN with cpu_rst_n=1 and mem_owner=0.
REQ-044 TIMEOUT_CYCLES=100, one write, then idle: ERR at cycle 100 after the write; load_err=1; a new start_pg edge returns to LOAD with load_err=0.
REQ-045 rst_n low mid-LOAD after 7 words: immediate RUN values; word_count=0; no further write enables.
REQ-046 upg_done edge, upg_wen and timeout all in one cycle: write forwarded, word_count incremented, next state HOLD.
